regfile_arbiter: RTL and testbench

Shares the single-port 16-bit register file between NREQ requesters, e.g. decode/execute, stack/PC update and the debug port. Each accepted request is sequenced into exactly one cycle of register-file control strobes (read, write, writeu, inc, dec). Read data and a completion pulse are returned to the originator. Arbitration is round-robin, with an optional lock so one requester can run an atomic multi-op sequence (e.g. read-then-dec).

---
 rtl/regfile_arbiter_if.sv | 44 ++++
 rtl/regfile_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Requester-side and register-file-side signal bundle for regfile_arbiter.
// The slave modport is the arbiter; the master modport is its environment
// (the requesters plus the register file that supplies rf_dout).
interface regfile_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int IDW  = 6
);
    // Requester handshake, one lane per requester, flattened lane-major
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_lock;
    logic [3*NREQ-1:0]   req_op;
    logic [IDW*NREQ-1:0] req_id;
    logic [DW*NREQ-1:0]  req_din;
    logic [NREQ-1:0]     req_ready;

    // Completion path back to the originator
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
    logic [NREQ-1:0]     lock_abort;

    // Register file control
    logic [DW-1:0]       rf_din;
    logic                rf_read;
    logic                rf_write;
    logic                rf_writeu;
    logic                rf_inc;
    logic                rf_dec;
    logic [IDW-1:0]      rf_id;
    logic [DW-1:0]       rf_dout;

    modport master (
        output req_valid, req_lock, req_op, req_id, req_din, rf_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_err, lock_abort,
        input  rf_din, rf_read, rf_write, rf_writeu, rf_inc, rf_dec, rf_id
    );

    modport slave (
        input  req_valid, req_lock, req_op, req_id, req_din, rf_dout,
        output req_ready, rsp_valid, rsp_data, rsp_err, lock_abort,
        output rf_din, rf_read, rf_write, rf_writeu, rf_inc, rf_dec, rf_id
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register file between NREQ
// requesters. Each accepted request becomes exactly one cycle of register
// file strobes (IDLE -> ISSUE -> DONE), followed by a one-cycle completion
// pulse to its originator. A requester may lock ownership across ops for
// atomic sequences; an idle lock is force-released after LOCK_TIMEOUT cycles.
module regfile_arbiter #(
    parameter int NREQ         = 3,
    parameter int DW           = 16,
    parameter int IDW          = 6,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_arbiter_if.slave   bus
);

    localparam int PW  = $clog2(NREQ);
    localparam int CW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_READ   = 3'd0;
    localparam logic [OPW-1:0] OP_WRITE  = 3'd1;
    localparam logic [OPW-1:0] OP_WRITEU = 3'd2;
    localparam logic [OPW-1:0] OP_INC    = 3'd3;
    localparam logic [OPW-1:0] OP_DEC    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Sequencer and arbitration state
    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic            locked_q, locked_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            illegal_q, illegal_d;

    // Registered register-file controls
    logic            rf_read_q, rf_read_d;
    logic            rf_write_q, rf_write_d;
    logic            rf_writeu_q, rf_writeu_d;
    logic            rf_inc_q, rf_inc_d;
    logic            rf_dec_q, rf_dec_d;
    logic [IDW-1:0]  rf_id_q, rf_id_d;
    logic [DW-1:0]   rf_din_q, rf_din_d;

    // Registered response
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    // Combinational arbitration results
    logic            grant;
    logic [PW-1:0]   grant_idx;
    logic            owner_hold;
    logic [OPW-1:0]  op_sel;
    logic [NREQ-1:0] ready_c;
    logic [NREQ-1:0] abort_c;

    // Requester index `offset` positions after `base`, wrapping at NREQ
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base,
                                               input int offset);
        int idx;
        idx = int'(base) + offset;
        if (idx >= NREQ) begin
            idx = idx - NREQ;
        end
        return PW'(idx);
    endfunction

    // Next-state, arbitration and strobe decode for the three-phase sequencer
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        locked_d    = locked_q;
        owner_d     = owner_q;
        lock_cnt_d  = lock_cnt_q;
        illegal_d   = illegal_q;
        rf_read_d   = 1'b0;
        rf_write_d  = 1'b0;
        rf_writeu_d = 1'b0;
        rf_inc_d    = 1'b0;
        rf_dec_d    = 1'b0;
        rf_id_d     = '0;
        rf_din_d    = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        grant       = 1'b0;
        grant_idx   = '0;
        owner_hold  = 1'b0;
        op_sel      = '0;
        ready_c     = '0;
        abort_c     = '0;

        case (state_q)
            ST_IDLE: begin
                // A lock only survives while its owner keeps req_lock high
                owner_hold = locked_q && bus.req_lock[owner_q];
                if (owner_hold) begin
                    if (lock_cnt_q == CW'(LOCK_TIMEOUT)) begin
                        // Idle too long: drop the lock, nobody granted this cycle
                        abort_c[owner_q] = 1'b1;
                        locked_d         = 1'b0;
                        lock_cnt_d       = '0;
                    end else if (bus.req_valid[owner_q]) begin
                        grant      = 1'b1;
                        grant_idx  = owner_q;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CW'(1);
                    end
                end else begin
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                    for (int k = 0; k < NREQ; k++) begin
                        if (!grant && bus.req_valid[rr_index(rr_ptr_q, k)]) begin
                            grant     = 1'b1;
                            grant_idx = rr_index(rr_ptr_q, k);
                        end
                    end
                end

                if (grant) begin
                    ready_c[grant_idx] = 1'b1;
                    rr_ptr_d  = rr_index(grant_idx, 1);
                    win_d     = grant_idx;
                    state_d   = ST_ISSUE;
                    op_sel    = bus.req_op[int'(grant_idx)*OPW +: OPW];
                    rf_id_d   = bus.req_id[int'(grant_idx)*IDW +: IDW];
                    rf_din_d  = bus.req_din[int'(grant_idx)*DW +: DW];
                    illegal_d = 1'b0;
                    case (op_sel)
                        OP_READ:   rf_read_d   = 1'b1;
                        OP_WRITE:  rf_write_d  = 1'b1;
                        OP_WRITEU: rf_writeu_d = 1'b1;
                        OP_INC:    rf_inc_d    = 1'b1;
                        OP_DEC:    rf_dec_d    = 1'b1;
                        default:   illegal_d   = 1'b1;
                    endcase
                end
            end

            ST_ISSUE: begin
                // Strobes fall back to their defaults; capture the result
                rsp_valid_d[win_q] = 1'b1;
                rsp_err_d          = illegal_q;
                if (rf_read_q) begin
                    rsp_data_d = bus.rf_dout;
                end else if (illegal_q) begin
                    rsp_data_d = '0;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                // Completing requester decides whether it keeps ownership
                if (bus.req_lock[win_q]) begin
                    locked_d   = 1'b1;
                    owner_d    = win_q;
                    lock_cnt_d = '0;
                end else begin
                    locked_d = 1'b0;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            locked_q    <= 1'b0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            illegal_q   <= 1'b0;
            rf_read_q   <= 1'b0;
            rf_write_q  <= 1'b0;
            rf_writeu_q <= 1'b0;
            rf_inc_q    <= 1'b0;
            rf_dec_q    <= 1'b0;
            rf_id_q     <= '0;
            rf_din_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            locked_q    <= locked_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            illegal_q   <= illegal_d;
            rf_read_q   <= rf_read_d;
            rf_write_q  <= rf_write_d;
            rf_writeu_q <= rf_writeu_d;
            rf_inc_q    <= rf_inc_d;
            rf_dec_q    <= rf_dec_d;
            rf_id_q     <= rf_id_d;
            rf_din_q    <= rf_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Combinational pulses are held off while reset is asserted so nobody
    // believes a request was taken by a sequencer that is being cleared.
    assign bus.req_ready  = ready_c & {NREQ{rst_n}};
    assign bus.lock_abort = abort_c & {NREQ{rst_n}};

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;

    assign bus.rf_read    = rf_read_q;
    assign bus.rf_write   = rf_write_q;
    assign bus.rf_writeu  = rf_writeu_q;
    assign bus.rf_inc     = rf_inc_q;
    assign bus.rf_dec     = rf_dec_q;
    assign bus.rf_id      = rf_id_q;
    assign bus.rf_din     = rf_din_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed testbench for regfile_arbiter: reset, round-robin order, write/read,
// lock sequencing, lock timeout, illegal op and reset during ISSUE.
module tb_regfile_arbiter;

    localparam int NREQ         = 3;
    localparam int DW           = 16;
    localparam int IDW          = 6;
    localparam int LOCK_TIMEOUT = 16;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_INC   = 3'd3;
    localparam logic [2:0] OP_DEC   = 3'd4;
    localparam logic [2:0] OP_BAD   = 3'd6;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

    regfile_arbiter #(
        .NREQ(NREQ), .DW(DW), .IDW(IDW), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file model: commits on the clock edge, reads combinationally
    logic [DW-1:0] rf_mem [64];
    always @(posedge clk) begin
        if (bus.rf_write || bus.rf_writeu) rf_mem[bus.rf_id] <= bus.rf_din;
        else if (bus.rf_inc)               rf_mem[bus.rf_id] <= rf_mem[bus.rf_id] + 16'd1;
        else if (bus.rf_dec)               rf_mem[bus.rf_id] <= rf_mem[bus.rf_id] - 16'd1;
    end
    assign bus.rf_dout = bus.rf_read ? rf_mem[bus.rf_id] : '0;

    logic [4:0] strobes;
    assign strobes = {bus.rf_read, bus.rf_write, bus.rf_writeu, bus.rf_inc, bus.rf_dec};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic v, input logic lk,
                           input logic [2:0] op, input logic [IDW-1:0] id,
                           input logic [DW-1:0] din);
        bus.req_valid[idx]          = v;
        bus.req_lock[idx]           = lk;
        bus.req_op[idx*3 +: 3]      = op;
        bus.req_id[idx*IDW +: IDW]  = id;
        bus.req_din[idx*DW +: DW]   = din;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, OP_READ, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
        tick(); tick(); settle();
        checks++; if (strobes !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b expected %b", strobes, 5'b0); end
        checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected %b", bus.req_ready, 3'b000); end
        checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected %b", bus.rsp_valid, 3'b000); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
        checks++; if (bus.lock_abort !== 3'b000) begin errors++; $display("FAIL reset_lock_abort: got %b expected %b", bus.lock_abort, 3'b000); end
        checks++; if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0000", bus.rsp_data); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        int g = 0;
        int last = 0;
        int multi = 0;
        logic [NREQ-1:0] exp;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, OP_READ, IDW'(3 + i), '0);
        for (int cyc = 0; cyc < 30 && g < 6; cyc++) begin
            settle();
            if ($countones(bus.req_ready) > 1) begin
                multi++;
            end else if (bus.req_ready != '0) begin
                exp = '0;
                exp[order[g]] = 1'b1;
                checks++; if (bus.req_ready !== exp) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", g, bus.req_ready, exp); end
                if (g > 0) begin
                    checks++; if (cyc - last !== 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected 3", g, cyc - last); end
                end
                last = cyc;
                g++;
            end
            if (g < 6) tick();
        end
        checks++; if (g !== 6) begin errors++; $display("FAIL rr_grant_count: got %0d expected 6", g); end
        checks++; if (multi !== 0) begin errors++; $display("FAIL rr_multi_ready: got %0d expected 0", multi); end
        tick(); clear_reqs();
        tick(); tick();
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 1'b0, OP_WRITE, 6'd1, 16'h0F0F);
        settle();
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL wr_ready: got %b expected 001", bus.req_ready); end
        tick(); set_req(0, 1'b0, 1'b0, OP_READ, '0, '0);
        settle();
        checks++; if (strobes !== 5'b01000) begin errors++; $display("FAIL wr_strobe: got %b expected 01000", strobes); end
        checks++; if (bus.rf_id !== 6'd1 || bus.rf_din !== 16'h0F0F) begin errors++; $display("FAIL wr_id_din: got %0d/%h expected 1/0f0f", bus.rf_id, bus.rf_din); end
        checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL wr_early_rsp: got %b expected 000", bus.rsp_valid); end
        tick(); settle();
        checks++; if (bus.rsp_valid !== 3'b001) begin errors++; $display("FAIL wr_rsp_valid: got %b expected 001", bus.rsp_valid); end
        tick();
        set_req(0, 1'b1, 1'b0, OP_READ, 6'd1, '0);
        settle();
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rd_ready: got %b expected 001", bus.req_ready); end
        tick(); clear_reqs();
        settle();
        checks++; if (strobes !== 5'b10000 || bus.rf_id !== 6'd1) begin errors++; $display("FAIL rd_strobe: got %b id %0d expected 10000 id 1", strobes, bus.rf_id); end
        tick(); settle();
        checks++; if (bus.rsp_valid !== 3'b001) begin errors++; $display("FAIL rd_rsp_valid: got %b expected 001", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 16'h0F0F) begin errors++; $display("FAIL rd_rsp_data: got %h expected 0f0f", bus.rsp_data); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_err: got %b expected 0", bus.rsp_err); end
        tick();
    endtask

    task automatic test_lock_sequence();
        // Seed id 2 with 0x00FF via requester 1 (rr_ptr is 1 here)
        set_req(1, 1'b1, 1'b0, OP_WRITE, 6'd2, 16'h00FF);
        settle();
        checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL lk_seed_ready: got %b expected 010", bus.req_ready); end
        tick(); clear_reqs();
        tick(); tick();
        // Locked READ, then INC while the other requesters compete
        set_req(1, 1'b1, 1'b1, OP_READ, 6'd2, '0);
        settle();
        checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL lk_read_ready: got %b expected 010", bus.req_ready); end
        tick();
        set_req(1, 1'b1, 1'b1, OP_INC, 6'd2, '0);
        set_req(0, 1'b1, 1'b0, OP_READ, 6'd1, '0);
        set_req(2, 1'b1, 1'b0, OP_READ, 6'd1, '0);
        settle();
        checks++; if (strobes !== 5'b10000 || bus.rf_id !== 6'd2) begin errors++; $display("FAIL lk_read_strobe: got %b id %0d expected 10000 id 2", strobes, bus.rf_id); end
        tick(); settle();
        checks++; if (bus.rsp_valid !== 3'b010 || bus.rsp_data !== 16'h00FF) begin errors++; $display("FAIL lk_read_rsp: got %b/%h expected 010/00ff", bus.rsp_valid, bus.rsp_data); end
        tick(); settle();
        checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL lk_second_grant: got %b expected 010", bus.req_ready); end
        tick();
        set_req(1, 1'b0, 1'b0, OP_READ, '0, '0);
        settle();
        checks++; if (strobes !== 5'b00010 || bus.rf_id !== 6'd2) begin errors++; $display("FAIL lk_inc_strobe: got %b id %0d expected 00010 id 2", strobes, bus.rf_id); end
        tick(); settle();
        checks++; if (bus.rsp_valid !== 3'b010) begin errors++; $display("FAIL lk_inc_rsp_valid: got %b expected 010", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 16'h00FF || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL lk_inc_rsp_hold: got %h/%b expected 00ff/0", bus.rsp_data, bus.rsp_err); end
        tick(); settle();
        checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL lk_after_release: got %b expected 100", bus.req_ready); end
        tick(); clear_reqs();
        tick(); tick();
    endtask

    task automatic test_lock_timeout();
        int bad = 0;
        set_req(1, 1'b1, 1'b1, OP_READ, 6'd2, '0);
        settle();
        checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL to_grant: got %b expected 010", bus.req_ready); end
        tick();
        set_req(1, 1'b0, 1'b1, OP_READ, 6'd2, '0);
        set_req(0, 1'b1, 1'b0, OP_READ, 6'd1, '0);
        tick(); settle();
        checks++; if (bus.rsp_valid !== 3'b010 || bus.rsp_data !== 16'h0100) begin errors++; $display("FAIL to_rsp: got %b/%h expected 010/0100", bus.rsp_valid, bus.rsp_data); end
        for (int k = 0; k < LOCK_TIMEOUT; k++) begin
            tick(); settle();
            if (bus.req_ready !== 3'b000 || bus.lock_abort !== 3'b000) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_held_cycles: got %0d active cycles expected 0", bad); end
        tick(); settle();
        checks++; if (bus.lock_abort !== 3'b010) begin errors++; $display("FAIL to_abort: got %b expected 010", bus.lock_abort); end
        checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL to_abort_ready: got %b expected 000", bus.req_ready); end
        tick(); settle();
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL to_resume_ready: got %b expected 001", bus.req_ready); end
        checks++; if (bus.lock_abort !== 3'b000) begin errors++; $display("FAIL to_abort_once: got %b expected 000", bus.lock_abort); end
        tick(); clear_reqs();
        tick(); tick();
    endtask

    task automatic test_illegal_op();
        set_req(2, 1'b1, 1'b0, OP_BAD, 6'd5, 16'hABCD);
        settle();
        checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL ill_ready: got %b expected 100", bus.req_ready); end
        tick(); clear_reqs();
        settle();
        checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL ill_no_strobe: got %b expected 00000", strobes); end
        tick(); settle();
        checks++; if (bus.rsp_valid !== 3'b100) begin errors++; $display("FAIL ill_rsp_valid: got %b expected 100", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL ill_rsp: got err %b data %h expected 1/0000", bus.rsp_err, bus.rsp_data); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        set_req(1, 1'b1, 1'b0, OP_DEC, 6'd2, '0);
        settle();
        checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL rm_ready: got %b expected 010", bus.req_ready); end
        tick(); clear_reqs();
        rst_n = 1'b0;
        settle();
        checks++; if (strobes !== 5'b00001 || bus.rf_id !== 6'd2) begin errors++; $display("FAIL rm_dec_strobe: got %b id %0d expected 00001 id 2", strobes, bus.rf_id); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, OP_READ, 6'd1, '0);
        settle();
        checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL rm_strobes_cleared: got %b expected 00000", strobes); end
        checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("FAIL rm_no_rsp: got %b expected 000", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rm_first_grant: got %b expected 001", bus.req_ready); end
        tick(); clear_reqs();
        tick(); settle();
        checks++; if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== 16'h0F0F) begin errors++; $display("FAIL rm_post_read: got %b/%h expected 001/0f0f", bus.rsp_valid, bus.rsp_data); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_lock_sequence();
        test_lock_timeout();
        test_illegal_op();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
